// File: rtl/iob_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// iob_cfg_loader_if
//
// Purpose : bundles the serial configuration stream and the per-IOB
//           configuration outputs of iob_cfg_loader.
//
// Signals :
//   CFG_DIN     serial configuration data bit (stream source -> loader)
//   CFG_VALID   CFG_DIN qualifier              (stream source -> loader)
//   TSMUX_OUT   2*NUM_IOB tristate mux selects, IOB i at [2i+1:2i]
//   DORREG_OUT  NUM_IOB input-path selects (0 direct, 1 registered)
//   CFG_BUSY    payload load in progress
//   CFG_DONE    configuration committed (sticky)
//   CFG_ERR     load rejected (sticky)
//
// Modports: master = stream source / observer, slave = the loader itself.
// ----------------------------------------------------------------------------
interface iob_cfg_loader_if #(
    parameter int NUM_IOB = 4
);
    logic                   CFG_DIN;
    logic                   CFG_VALID;
    logic [2*NUM_IOB-1:0]   TSMUX_OUT;
    logic [NUM_IOB-1:0]     DORREG_OUT;
    logic                   CFG_BUSY;
    logic                   CFG_DONE;
    logic                   CFG_ERR;

    modport master (
        output CFG_DIN, CFG_VALID,
        input  TSMUX_OUT, DORREG_OUT, CFG_BUSY, CFG_DONE, CFG_ERR
    );

    modport slave (
        input  CFG_DIN, CFG_VALID,
        output TSMUX_OUT, DORREG_OUT, CFG_BUSY, CFG_DONE, CFG_ERR
    );
endinterface

// File: rtl/iob_cfg_loader.sv
// ----------------------------------------------------------------------------
// iob_cfg_loader
//
// Purpose : serial configuration loader sitting directly in front of the
//           I/O blocks. Hunts a sync word on a 1-bit stream, shifts in
//           3 bits per IOB (TSMUX[1], TSMUX[0], DORREG; IOB0 first) into a
//           staging register, then commits every IOB setting in one edge.
//           Until a commit all IOBs sit in the safe high-Z / direct-input
//           state (all outputs 0).
//
// Ports   :
//   IOCLK  configuration clock, all state on the rising edge
//   RST    synchronous, active-high reset
//   bus    iob_cfg_loader_if.slave (stream in, IOB configuration out)
//
// Options : define IOB_CFG_PARITY_EN to require one trailing even-parity bit
//           after the payload; a parity failure lands in the sticky ERR
//           state. Without it CFG_ERR is tied to 0.
// ----------------------------------------------------------------------------
module iob_cfg_loader #(
    parameter int                NUM_IOB   = 4,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
    input  logic              IOCLK,
    input  logic              RST,
    iob_cfg_loader_if.slave   bus
);

    localparam int PAYLOAD_W = 3 * NUM_IOB;
`ifdef IOB_CFG_PARITY_EN
    localparam int LOAD_BITS = PAYLOAD_W + 1;
`else
    localparam int LOAD_BITS = PAYLOAD_W;
`endif
    localparam int              CNT_W    = $clog2(LOAD_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BITS - 1);
`ifdef IOB_CFG_PARITY_EN
    localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(PAYLOAD_W);
`endif

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LOAD,
        ST_COMMIT,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_W-1:0]      sync_q, sync_d;
    logic [PAYLOAD_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*NUM_IOB-1:0]   tsmux_q, tsmux_d;
    logic [NUM_IOB-1:0]     dorreg_q, dorreg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef IOB_CFG_PARITY_EN
    logic                   par_q, par_d;
    logic                   err_q, err_d;
`endif

    logic [SYNC_W-1:0]      sync_shift;
    logic [PAYLOAD_W-1:0]   stage_shift;
    logic [2*NUM_IOB-1:0]   stage_ts;
    logic [NUM_IOB-1:0]     stage_dor;

    assign sync_shift  = {sync_q[SYNC_W-2:0], bus.CFG_DIN};
    assign stage_shift = {stage_q[PAYLOAD_W-2:0], bus.CFG_DIN};

    // The staging register shifts LSB-in, so payload bit k (first bit k=0)
    // ends up at position PAYLOAD_W-1-k. Unscramble into per-IOB fields.
    always_comb begin
        stage_ts  = '0;
        stage_dor = '0;
        for (int i = 0; i < NUM_IOB; i++) begin
            stage_ts[2*i+1] = stage_q[PAYLOAD_W-1-3*i];
            stage_ts[2*i]   = stage_q[PAYLOAD_W-2-3*i];
            stage_dor[i]    = stage_q[PAYLOAD_W-3-3*i];
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sync_d   = sync_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        tsmux_d  = tsmux_q;
        dorreg_d = dorreg_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef IOB_CFG_PARITY_EN
        par_d    = par_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (bus.CFG_VALID) begin
                    sync_d = sync_shift;
                    // Sliding window: compare including the bit being sampled.
                    if (sync_shift == SYNC_WORD) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
`ifdef IOB_CFG_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end
                end
            end
            ST_LOAD: begin
                if (bus.CFG_VALID) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef IOB_CFG_PARITY_EN
                    // The trailing parity bit is folded into the parity
                    // accumulator but never enters the staging register.
                    if (cnt_q < PAY_CNT) stage_d = stage_shift;
                    par_d = par_q ^ bus.CFG_DIN;
                    if (cnt_q == LAST_CNT) begin
                        if (par_q ^ bus.CFG_DIN) begin
                            state_d = ST_ERR;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_COMMIT;
                        end
                    end
`else
                    stage_d = stage_shift;
                    if (cnt_q == LAST_CNT) state_d = ST_COMMIT;
`endif
                end
            end
            ST_COMMIT: begin
                tsmux_d  = stage_ts;
                dorreg_d = stage_dor;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_DONE;
            end
            default: ;  // DONE and ERR are terminal until RST
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q  <= ST_HUNT;
            sync_q   <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            tsmux_q  <= '0;
            dorreg_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef IOB_CFG_PARITY_EN
            par_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            tsmux_q  <= tsmux_d;
            dorreg_q <= dorreg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef IOB_CFG_PARITY_EN
            par_q    <= par_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.TSMUX_OUT  = tsmux_q;
    assign bus.DORREG_OUT = dorreg_q;
    assign bus.CFG_BUSY   = busy_q;
    assign bus.CFG_DONE   = done_q;
`ifdef IOB_CFG_PARITY_EN
    assign bus.CFG_ERR    = err_q;
`else
    assign bus.CFG_ERR    = 1'b0;
`endif

endmodule

// File: doc/iob_cfg_loader.md
Name: iob_cfg_loader

Overview:
- Serial configuration loader directly upstream of the I/O blocks.
- Hunts a sync word on a 1-bit configuration stream, then shifts in per-IOB settings: 2-bit tristate mux select and 1-bit direct/registered input select.
- Commits all settings atomically to the IOB configuration inputs.
- Until a commit, it holds every IOB in the safe high-Z, direct-input state.

Parameters:
- NUM_IOB, 4: number of I/O blocks configured; legal range 1..32.
- SYNC_W, 8: sync word width in bits.
- SYNC_WORD, 8'hA5: sync pattern, matched MSB-first.

Ports:
- IOCLK  input  1  configuration clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- CFG_DIN  input  1  serial configuration data bit.
- CFG_VALID  input  1  CFG_DIN is sampled only on edges where this is 1.
- TSMUX_OUT  output  2*NUM_IOB  tristate mux select; IOB i uses bits [2i+1:2i].
- DORREG_OUT  output  NUM_IOB  input-path select; bit i is for IOB i; 0 = direct pin, 1 = registered.
- CFG_BUSY  output  1  payload load in progress.
- CFG_DONE  output  1  configuration committed; sticky.
- CFG_ERR  output  1  load rejected; sticky.

Behaviour:
- Reset: on a rising edge with RST=1, the block returns to the following state regardless of current state, including mid-load:
  - state HUNT
  - TSMUX_OUT all 0, DORREG_OUT all 0
  - CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0
  - sync shift register, staging register and bit counter cleared.
  - RST has priority over CFG_VALID.
- Edges with CFG_VALID=0 change nothing except under RST.
- States: HUNT, LOAD, COMMIT, DONE, ERR.
- HUNT:
  - Each valid bit shifts into a SYNC_W-bit register, LSB in.
  - If {register[SYNC_W-2:0], CFG_DIN} == SYNC_WORD on the sampling edge, go to LOAD: counter=0, CFG_BUSY=1 after that edge.
  - Overlapping partial matches are honoured; this is a sliding window.
- LOAD:
  - Payload is exactly 3*NUM_IOB valid bits.
  - Order is IOB0 first; per IOB: TSMUX[1], TSMUX[0], DORREG.
  - Bits go into the staging register only; outputs are unchanged.
  - The counter increments per valid bit. On the edge sampling bit 3*NUM_IOB-1, go to COMMIT.
- COMMIT (one cycle, independent of CFG_VALID):
  - Next edge copies staging to TSMUX_OUT/DORREG_OUT atomically, sets CFG_DONE=1 and CFG_BUSY=0, and goes to DONE.
  - Latency: outputs valid one edge after the last payload bit is sampled.
- DONE:
  - Terminal; all further CFG_VALID bits are ignored, including another sync word.
  - Outputs are held until RST.
- ERR:
  - Terminal; outputs keep their reset values, CFG_BUSY=0, CFG_ERR=1 until RST.
- All TSMUX codes are legal (00 high-Z, 01 TS-gated, 10/11 always drive); no decode checking.
- Outputs never show partial configuration: no output bit changes except at COMMIT or RST.

Optional Feature:
- Macro: IOB_CFG_PARITY_EN.
- With the macro defined:
  - LOAD accepts one extra valid bit after the payload: an even-parity bit over the 3*NUM_IOB payload bits.
  - The edge sampling the parity bit goes to COMMIT if the total count of ones, parity included, is even. Otherwise it goes to ERR: CFG_ERR=1 and CFG_BUSY=0 on the next edge, no commit.
- Without the macro:
  - No parity bit; COMMIT follows the last payload bit.
  - CFG_ERR is constant 0 and ERR is unreachable.

Test Plan (NUM_IOB=4, SYNC_WORD=8'hA5):
- Reset then idle -> TSMUX_OUT=8'h00, DORREG_OUT=4'h0, BUSY/DONE/ERR=0.
- Stream 1010_0101, then 12 payload bits 011_100_111_000 (plus parity bit 0 if enabled) -> one edge after the last bit: TSMUX_OUT=8'b00_11_10_01, DORREG_OUT=4'b0101, CFG_DONE=1, CFG_BUSY=0. Outputs must be unchanged on every earlier edge.
- Same stream with CFG_VALID deasserted for 3 cycles mid-payload -> identical final result; commit is delayed by 3 cycles.
- Noise 1101_0 before the sync word, then a valid load -> sync found through the sliding window; correct commit. A second A5 plus payload after DONE -> outputs unchanged.
- RST asserted after 6 payload bits -> outputs stay 0 and BUSY=0 on the next edge. A fresh full load then commits correctly.
- IOB_CFG_PARITY_EN defined, valid payload with parity bit 1 (wrong) -> CFG_ERR=1, CFG_DONE=0, outputs remain 0.
